// File: rtl/pipe_stage_reg.sv
// Pipeline stage register between two CPU stages.
// Supports stall (hold), bubble insertion (flush) and exception redirect (req).
module pipe_stage_reg #(
    parameter int unsigned PAYLOAD_W = 32,
    parameter bit          TNEW_DEC  = 1'b1,
    parameter logic [31:0] PC_RST    = 32'h0000_3000,
    parameter logic [31:0] EXC_PC    = 32'h0000_4180
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 req,
    input  logic [31:0]          i_pc,
    input  logic                 i_regwe,
    input  logic [4:0]           i_A3,
    input  logic [1:0]           i_Tnew,
    input  logic [4:0]           i_rtad,
    input  logic                 i_bd,
    input  logic [4:0]           i_exccode,
    input  logic                 i_valid,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic [31:0]          o_pc,
    output logic                 o_regwe,
    output logic [4:0]           o_A3,
    output logic [1:0]           o_Tnew,
    output logic [4:0]           o_rtad,
    output logic                 o_bd,
    output logic [4:0]           o_exccode,
    output logic                 o_valid,
    output logic [PAYLOAD_W-1:0] o_payload
);

    logic [31:0]          pc_q, pc_d;
    logic                 regwe_q, regwe_d;
    logic [4:0]           a3_q, a3_d;
    logic [1:0]           tnew_q, tnew_d;
    logic [4:0]           rtad_q, rtad_d;
    logic                 bd_q, bd_d;
    logic [4:0]           exccode_q, exccode_d;
    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    // Tnew as captured on a load; saturates at zero and collapses to zero for bubbles.
    logic [1:0] tnew_load;

    always_comb begin
        tnew_load = i_Tnew;
        if (!i_valid) begin
            tnew_load = 2'd0;
        end else if (TNEW_DEC && (i_Tnew != 2'd0)) begin
            tnew_load = i_Tnew - 2'd1;
        end
    end

    always_comb begin
        pc_d      = pc_q;
        regwe_d   = regwe_q;
        a3_d      = a3_q;
        tnew_d    = tnew_q;
        rtad_d    = rtad_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        valid_d   = valid_q;
        payload_d = payload_q;

        if (req) begin
            pc_d      = EXC_PC;
            regwe_d   = 1'b0;
            a3_d      = '0;
            tnew_d    = '0;
            rtad_d    = '0;
            bd_d      = 1'b0;
            exccode_d = '0;
            valid_d   = 1'b0;
            payload_d = '0;
        end else if (flush) begin
            // pc/bd survive the bubble so a later exception can report the right EPC.
            pc_d      = i_pc;
            regwe_d   = 1'b0;
            a3_d      = '0;
            tnew_d    = '0;
            rtad_d    = '0;
            bd_d      = i_bd;
            exccode_d = '0;
            valid_d   = 1'b0;
            payload_d = '0;
        end else if (en) begin
            pc_d      = i_pc;
            regwe_d   = i_regwe && i_valid && (i_exccode == 5'd0);
            a3_d      = i_A3;
            tnew_d    = tnew_load;
            rtad_d    = i_rtad;
            bd_d      = i_bd;
            exccode_d = i_exccode;
            valid_d   = i_valid;
            payload_d = i_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= PC_RST;
            regwe_q   <= 1'b0;
            a3_q      <= '0;
            tnew_q    <= '0;
            rtad_q    <= '0;
            bd_q      <= 1'b0;
            exccode_q <= '0;
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            pc_q      <= pc_d;
            regwe_q   <= regwe_d;
            a3_q      <= a3_d;
            tnew_q    <= tnew_d;
            rtad_q    <= rtad_d;
            bd_q      <= bd_d;
            exccode_q <= exccode_d;
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign o_pc      = pc_q;
    assign o_regwe   = regwe_q;
    assign o_A3      = a3_q;
    assign o_Tnew    = tnew_q;
    assign o_rtad    = rtad_q;
    assign o_bd      = bd_q;
    assign o_exccode = exccode_q;
    assign o_valid   = valid_q;
    assign o_payload = payload_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter PAYLOAD_W, 32, width of the generic stage payload (e.g. ALU result, memory data).
REQ-002 The block SHALL have parameter TNEW_DEC, 1, where 1 means Tnew decrements on capture and 0 means Tnew passes through unchanged.
REQ-003 The block SHALL have parameter PC_RST, 32'h0000_3000, the pc value loaded on reset.
REQ-004 The block SHALL have parameter EXC_PC, 32'h0000_4180, the pc value loaded on exception request.

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-007 The block SHALL have port en, input, 1: 1 = capture, 0 = stall/hold.
REQ-008 The block SHALL have port flush, input, 1, which inserts a bubble.
REQ-009 The block SHALL have port req, input, 1, an exception/interrupt flush.
REQ-010 The block SHALL have inputs i_pc (32), i_regwe (1), i_A3 (5), i_Tnew (2), i_rtad (5), i_bd (1), i_exccode (5), i_valid (1) and i_payload (PAYLOAD_W).
REQ-011 The block SHALL provide registered outputs o_pc, o_regwe, o_A3, o_Tnew, o_rtad, o_bd, o_exccode, o_valid and o_payload, each the same width as its input.

Function
REQ-012 On each rising clk edge, exactly one action SHALL apply, in priority order: reset > req > flush > hold (en=0) > load.
REQ-013 Load (en=1, no higher-priority input asserted) SHALL capture every input into its output register.
REQ-014 On load, o_Tnew SHALL be i_Tnew-1 when TNEW_DEC=1 and i_Tnew>0; otherwise it SHALL equal i_Tnew (it never wraps below 0).
REQ-015 On load with i_exccode != 0, o_regwe SHALL be forced to 0 (a faulting instruction never writes the register file); all other fields capture normally.
REQ-016 On load with i_valid=0, o_regwe SHALL be forced to 0 and o_Tnew to 0.
REQ-017 Hold (en=0) SHALL keep all outputs unchanged, including o_Tnew (no decrement while stalled).
REQ-018 Flush (bubble) SHALL set o_pc=i_pc and o_bd=i_bd, and SHALL clear o_regwe, o_A3, o_Tnew, o_rtad, o_exccode, o_valid and o_payload to 0; keeping pc and bd lets exception handling report the stalled instruction's EPC.
REQ-019 Flush SHALL override en=0 (stall and flush in the same cycle yields a bubble).
REQ-020 Req SHALL set o_pc=EXC_PC and clear every other output to 0, regardless of en and flush.
REQ-021 Latency SHALL be one cycle from input to output; there is no combinational path from inputs to outputs.
REQ-022 All outputs SHALL be driven only by registers.

Reset
REQ-023 On reset=1 at a clk edge, o_pc SHALL be PC_RST and all other outputs SHALL be 0.
REQ-024 Reset SHALL dominate req, flush and en in the same cycle.
REQ-025 Reset asserted mid-stall SHALL discard the held contents, and the first edge after reset deasserts SHALL follow REQ-012 normally.
REQ-026 Before the first reset the block SHALL NOT be required to hold any defined value.

Verification
REQ-027 Reset then load i_pc=32'h3004, i_Tnew=2, i_regwe=1, i_A3=5'd8, i_valid=1 -> next cycle o_pc=32'h3004, o_Tnew=1 (TNEW_DEC=1) or 2 (TNEW_DEC=0), o_regwe=1, o_A3=8.
REQ-028 Load, then en=0 for 3 cycles while the inputs change -> outputs stay at the loaded values and o_Tnew does not decrement.
REQ-029 flush=1 and en=0 with i_pc=32'h3010, i_bd=1, i_regwe=1 -> o_pc=32'h3010, o_bd=1, o_regwe=0, o_valid=0, o_exccode=0.
REQ-030 req=1 together with flush=1 and en=1 -> o_pc=32'h4180 and all other outputs 0; then reset=1 together with req=1 -> o_pc=32'h3000.
REQ-031 Load i_exccode=5'd4, i_regwe=1, i_Tnew=0 -> o_exccode=4, o_regwe=0, o_Tnew=0 (no underflow).
REQ-032 Load with i_valid=0, i_regwe=1, i_Tnew=2 -> o_regwe=0, o_Tnew=0, o_valid=0.
